// File: rtl/gt_link_pkg.sv
// Shared GT link definitions: requester indices, arbiter state type, word width.
package gt_link_pkg;

    localparam int REQ_NORTH = 0;
    localparam int REQ_SOUTH = 1;
    localparam int REQ_CTRL  = 2;

    localparam int GT_WORD_W = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating first-one finder: returns the first set request at or after start, wrapping modulo N.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] start_i,
    output logic          found_o,
    output logic [PW-1:0] idx_o
);

    always_comb begin
        logic [PW-1:0] pos;
        found_o = |req_i;
        idx_o   = '0;
        pos     = '0;
        // Scan from the farthest offset back to start so the nearest hit is written last.
        for (int k = N - 1; k >= 0; k--) begin
            pos = PW'((int'(start_i) + k) % N);
            if (req_i[pos]) begin
                idx_o = pos;
            end
        end
    end

endmodule

// File: rtl/gt_tx_arbiter.sv
// Burst-limited round-robin scheduler for the GT transmit link with a single output register.
// Optional per-requester grant counters are built when GT_TX_ARB_STATS_EN is defined.
module gt_tx_arbiter
    import gt_link_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = GT_WORD_W,
    parameter int BURST_MAX  = 4,
    parameter int PTR_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PTR_W-1:0]              owner,
    output logic                          busy,
    output logic [NUM_REQ*16-1:0]         grant_count,
    input  logic                          stats_clear
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BMAX = CNT_W'(BURST_MAX);

    // Every port pair transfers on a clock edge where valid && ready; a source holds
    // its word stable while valid && !ready, and ready never depends on a later cycle.
    arb_state_t            state_q, state_d;
    logic [PTR_W-1:0]      owner_q, owner_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic                  load_en;
    logic                  continue_burst;
    logic                  pick_found;
    logic [PTR_W-1:0]      pick_idx;
    logic                  grant_vld;
    logic [PTR_W-1:0]      grant_idx;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_REQ-1:0]    xfer;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_rr_pick (
        .req_i   (req_valid),
        .start_i (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        load_en        = !out_valid_q || out_ready;
        continue_burst = (state_q == BURST) && req_valid[owner_q] && (burst_cnt_q < BMAX);
        grant_vld      = load_en && (continue_burst || pick_found);
        grant_idx      = continue_burst ? owner_q : pick_idx;
        sel_data       = '0;
        xfer           = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                xfer[i]  = grant_vld && req_valid[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (grant_vld) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            owner_d     = grant_idx;
            state_d     = BURST;
            burst_cnt_d = continue_burst ? burst_cnt_q + CNT_W'(1) : CNT_W'(1);
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (load_en) begin
                state_d = IDLE;
            end
        end

        // A full burst hands the search to the next index; so does an owner that lost the grant.
        if (grant_vld && (burst_cnt_d == BMAX)) begin
            rr_ptr_d = ptr_inc(grant_idx);
        end else if (load_en && (state_q == BURST) && !(grant_vld && (grant_idx == owner_q))) begin
            rr_ptr_d = ptr_inc(owner_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef GT_TX_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] grant_cnt_q;

    // Clear takes precedence over a coincident grant.
    always_ff @(posedge clk) begin
        if (reset || stats_clear) begin
            grant_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign grant_count = grant_cnt_q;
`else
    logic unused_stats_clear;
    assign unused_stats_clear = stats_clear;
    assign grant_count        = '0;
`endif

    assign req_ready = xfer;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign owner     = owner_q;
    assign busy      = (|req_valid) || out_valid_q;

endmodule

// File: tb/tb_gt_tx_arbiter.sv
// Bench for gt_tx_arbiter: vector table, directed reset/stats sequences and a randomized run
// against a run-length based scheduling model with an expected-word queue.
module tb_gt_tx_arbiter;
    import gt_link_pkg::*;

    localparam int N  = 3;
    localparam int DW = 64;
    localparam int BM = 4;
    localparam int PW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic [PW-1:0]   owner;
    logic            busy;
    logic [N*16-1:0] grant_count;
    logic            stats_clear;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    int seq[N];

    typedef struct packed {
        logic [N-1:0] vld;
        logic         ordy;
        logic [N-1:0] rdy;
    } vec_t;

    vec_t tbl[35];
    int   nvec = 0;

    gt_tx_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM),
        .PTR_W      (PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .owner       (owner),
        .busy        (busy),
        .grant_count (grant_count),
        .stats_clear (stats_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        out_ready   = 1'b0;
        stats_clear = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic add_vec(input logic [N-1:0] v, input logic r, input logic [N-1:0] e);
        tbl[nvec] = '{vld: v, ordy: r, rdy: e};
        nvec++;
    endtask

    function automatic logic [DW-1:0] word_of(input int i, input int s);
        return {8'hA0 + 8'(i), 24'h0, 32'(s)};
    endfunction

    task automatic drive_idle_cycles(input logic [N-1:0] v, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            req_valid = v;
            out_ready = 1'b1;
            for (int i = 0; i < N; i++) req_data[i*DW +: DW] = word_of(i, c);
        end
    endtask

    task automatic run_table(input int first, input int last);
        logic          ov_e;
        logic [DW-1:0] last_w;
        ov_e   = 1'b0;
        last_w = '0;
        for (int i = 0; i < N; i++) seq[i] = 0;
        for (int r = first; r <= last; r++) begin
            @(negedge clk);
            req_valid = tbl[r].vld;
            out_ready = tbl[r].ordy;
            for (int i = 0; i < N; i++) req_data[i*DW +: DW] = word_of(i, seq[i]);
            #1;
            check($sformatf("tbl%0d_req_ready", r), 64'(req_ready), 64'(tbl[r].rdy));
            check($sformatf("tbl%0d_busy", r), 64'(busy), 64'((|tbl[r].vld) || ov_e));
            check($sformatf("tbl%0d_out_valid", r), 64'(out_valid), 64'(ov_e));
            if (ov_e) check($sformatf("tbl%0d_out_data", r), out_data, last_w);
            if (tbl[r].rdy != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (tbl[r].rdy[i]) begin
                        last_w = word_of(i, seq[i]);
                        seq[i]++;
                    end
                end
                ov_e = 1'b1;
            end else if (ov_e && tbl[r].ordy) begin
                ov_e = 1'b0;
            end
        end
    endtask

    // Scheduling model: current run (owner and run length) and the next search start.
    bit   m_active;
    int   m_owner, m_run, m_ptr;
    bit   m_ov;
    int   m_cnt[N];

    task automatic run_random(input int ncyc);
        logic [N-1:0] prev_v, prev_r;
        bit le, cont, was_active;
        int g, old_owner, j;
        logic [N-1:0] exp_r;
        prev_v = '0;
        prev_r = '0;
        m_active = 0; m_owner = 0; m_run = 0; m_ptr = 0; m_ov = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!(prev_v[i] && !prev_r[i])) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_data[i*DW +: DW] = {$urandom, $urandom};
                end
            end
            out_ready   = ($urandom_range(0, 3) != 0);
            stats_clear = ($urandom_range(0, 63) == 0);
            #1;
            le = !m_ov || out_ready;
            g = -1;
            cont = 0;
            if (le) begin
                if (m_active && req_valid[m_owner] && m_run < BM) begin
                    g = m_owner;
                    cont = 1;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        j = (m_ptr + k) % N;
                        if (g < 0 && req_valid[j]) g = j;
                    end
                end
            end
            exp_r = (g >= 0) ? N'(1 << g) : '0;
            check("rnd_req_ready", 64'(req_ready), 64'(exp_r));
            check("rnd_out_valid", 64'(out_valid), 64'(m_ov));
            check("rnd_busy", 64'(busy), 64'((|req_valid) || m_ov));
            check("rnd_owner", 64'(owner), 64'(m_owner));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_out_word: got %h expected none", out_data);
                end else begin
                    check("rnd_out_word", out_data, exp_q.pop_front());
                end
            end
            if (g >= 0) exp_q.push_back(req_data[g*DW +: DW]);

            old_owner  = m_owner;
            was_active = m_active;
            if (stats_clear) begin
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
            end else if (g >= 0 && m_cnt[g] < 65535) begin
                m_cnt[g]++;
            end
            if (g >= 0) begin
                m_ov = 1;
                if (cont) m_run++;
                else begin
                    m_run = 1;
                    m_owner = g;
                end
                m_active = 1;
                if (m_run == BM) m_ptr = (g + 1) % N;
                else if (was_active && g != old_owner) m_ptr = (old_owner + 1) % N;
            end else begin
                if (m_ov && out_ready) m_ov = 0;
                if (le) begin
                    if (was_active) m_ptr = (old_owner + 1) % N;
                    m_active = 0;
                end
            end
            prev_v = req_valid;
            prev_r = req_ready;
        end
        stats_clear = 1'b0;
        check("rnd_queue_depth", 64'(exp_q.size()), 64'(m_ov));
        for (int i = 0; i < N; i++) begin
`ifdef GT_TX_ARB_STATS_EN
            check($sformatf("rnd_grant_count%0d", i), 64'(grant_count[i*16 +: 16]), 64'(m_cnt[i]));
`else
            check($sformatf("rnd_grant_count%0d", i), 64'(grant_count[i*16 +: 16]), 64'd0);
`endif
        end
    endtask

    initial begin
        // single requester, 4+2 split without a bubble, then drain
        for (int k = 0; k < 6; k++) add_vec(3'b010, 1'b1, 3'b010);
        add_vec(3'b000, 1'b1, 3'b000);
        add_vec(3'b000, 1'b1, 3'b000);
        // fairness with all requesters valid
        for (int k = 0; k < 4; k++) add_vec(3'b111, 1'b1, 3'b001);
        for (int k = 0; k < 4; k++) add_vec(3'b111, 1'b1, 3'b010);
        for (int k = 0; k < 4; k++) add_vec(3'b111, 1'b1, 3'b100);
        add_vec(3'b111, 1'b1, 3'b001);
        // backpressure mid-burst: burst count must resume at 3
        add_vec(3'b011, 1'b1, 3'b001);
        add_vec(3'b011, 1'b1, 3'b001);
        for (int k = 0; k < 5; k++) add_vec(3'b011, 1'b0, 3'b000);
        add_vec(3'b011, 1'b1, 3'b001);
        add_vec(3'b011, 1'b1, 3'b001);
        add_vec(3'b011, 1'b1, 3'b010);
        // early burst end, then search must start at 1
        add_vec(3'b101, 1'b1, 3'b001);
        add_vec(3'b101, 1'b1, 3'b001);
        add_vec(3'b100, 1'b1, 3'b100);
        add_vec(3'b011, 1'b1, 3'b010);

        reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        out_ready = 1'b0;
        stats_clear = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant_count", 64'(grant_count), 64'd0);

        do_reset(); run_table(0, 7);
        do_reset(); run_table(8, 20);
        do_reset(); run_table(21, 30);
        do_reset(); run_table(31, 34);

        // reset in the middle of a burst from requester 2
        do_reset();
        drive_idle_cycles(3'b100, 3);
        @(negedge clk);
        req_valid = '0;
        out_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_owner_before", 64'(owner), 64'd2);
        check("midrst_out_valid_before", 64'(out_valid), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_owner", 64'(owner), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_out_data", out_data, 64'd0);
        req_valid = 3'b111;
        out_ready = 1'b1;
        #1;
        check("midrst_first_grant", 64'(req_ready), 64'b001);

        // statistics: 10 grants to 0, 3 to 1, then clear coinciding with a grant
        do_reset();
        drive_idle_cycles(3'b001, 10);
        drive_idle_cycles(3'b010, 3);
        drive_idle_cycles(3'b000, 1);
        #1;
`ifdef GT_TX_ARB_STATS_EN
        check("stats_cnt0", 64'(grant_count[15:0]), 64'd10);
        check("stats_cnt1", 64'(grant_count[31:16]), 64'd3);
`else
        check("stats_cnt0", 64'(grant_count[15:0]), 64'd0);
        check("stats_cnt1", 64'(grant_count[31:16]), 64'd0);
`endif
        check("stats_cnt2", 64'(grant_count[47:32]), 64'd0);
        @(negedge clk);
        req_valid = 3'b001;
        stats_clear = 1'b1;
        @(negedge clk);
        req_valid = '0;
        stats_clear = 1'b0;
        #1;
        check("stats_clear_cnt0", 64'(grant_count[15:0]), 64'd0);
        check("stats_clear_cnt1", 64'(grant_count[31:16]), 64'd0);

        do_reset();
        run_random(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gt_tx_arbiter.md
Name: gt_tx_arbiter

Overview:
- Schedules the single GT transmit link among NUM_REQ word streams: the north border combiner, the south border combiner and the control channel.
- Replaces fixed-priority selection with burst-limited round-robin, so no requester can starve another.
- Provides a registered output stage that feeds the outbound GT FIFO.
- Sits between the per-direction combiners / control path and the out-data FIFO of the message handler.

Parameters:
- NUM_REQ, 3, number of requesters (index 0 = north, 1 = south, 2 = control).
- DATA_WIDTH, 64, word width (GT_FIFO_SIZE).
- BURST_MAX, 4, maximum consecutive grants to one requester while others wait (>=1).
- PTR_W, $clog2(NUM_REQ), width of the owner/pointer index (derived).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_data  input  NUM_REQ*DATA_WIDTH  requester words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_valid  input  NUM_REQ  requester word valid.
- req_ready  output  NUM_REQ  requester word accepted this cycle.
- out_data  output  DATA_WIDTH  registered selected word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream (GT FIFO) accepts.
- owner  output  PTR_W  index of the most recently granted requester.
- busy  output  1  high when any req_valid is high or out_valid is high.
- grant_count  output  NUM_REQ*16  per-requester grant counters (see Optional Feature).
- stats_clear  input  1  clears grant_count.

Behaviour:
- Handshake: a transfer occurs when valid && ready on a cycle edge. Data must be held stable while valid && !ready.
- Load enable: load_en = !out_valid || out_ready. This is a single register stage, so a full-throughput stream sustains 1 word/cycle.
- Grant is combinational each cycle:
  - If state==BURST, req_valid[owner]==1 and burst_cnt<BURST_MAX, then grant=owner.
  - Otherwise grant = the first i with req_valid[i]==1, searching cyclically from rr_ptr (rr_ptr, rr_ptr+1, ... mod NUM_REQ).
  - No requester valid: no grant.
- req_ready[i] = load_en && (grant==i) && req_valid[i]. At most one bit is set; the value is 0 when no grant exists.
- On a transfer from requester g:
  - out_data<=req_data[g], out_valid<=1.
  - If g == owner and state==BURST, burst_cnt<=burst_cnt+1; otherwise burst_cnt<=1, owner<=g, state<=BURST.
- Output drain: if out_ready && out_valid and there is no new transfer, out_valid<=0.
- State machine:
  - IDLE→BURST on the first grant.
  - BURST→IDLE when the cycle has no grant and load_en=1.
  - Burst end: when the owner is not granted on a load_en cycle, or burst_cnt reaches BURST_MAX, rr_ptr<=owner+1 (mod NUM_REQ, wrapping NUM_REQ-1→0).
  - When burst_cnt==BURST_MAX, the next search starts at owner+1. The owner may win again only if no other requester is valid; this restarts burst_cnt at 1.
- Stalls (load_en=0): no grant, all req_ready=0; state, owner, burst_cnt and rr_ptr hold.
- Simultaneous requests: resolved only by the rr_ptr search order; there is no fixed priority.
- Reset: out_valid=0, out_data=0, req_ready=0, owner=0, rr_ptr=0, burst_cnt=0, state=IDLE, grant_count=0.
  - Reset mid-burst drops the buffered word. Upstream must also be reset.
- busy is combinational: |req_valid || out_valid.
- Widths: burst_cnt is $clog2(BURST_MAX+1) bits and never exceeds BURST_MAX.

Optional Feature:
- Macro GT_TX_ARB_STATS_EN.
- Defined:
  - grant_count[i] increments by 1 on each transfer from requester i and saturates at 16'hFFFF.
  - stats_clear=1 zeroes all counters the next cycle. When it coincides with a grant, the clear wins and the result is 0.
- Undefined: grant_count is tied to 0, stats_clear is ignored, and no counter flops are built.

Decomposition:
- Shared package gt_link_pkg:
  - Requester index constants REQ_NORTH=0, REQ_SOUTH=1, REQ_CTRL=2.
  - State typedef arb_state_t {IDLE, BURST}.
  - GT_WORD_W=64.
- One natural sub-module, rr_pick: a combinational rotating first-one finder (inputs: request vector, start pointer; outputs: found flag, index).
- Everything else (output register stage, burst counter, statistics counters) stays in gt_tx_arbiter.

Test Plan:
- Single requester: only req1 valid, 6 words A0..A5, out_ready=1 → words on out_data in order, one per cycle, starting 1 cycle after the first req_ready; bursts split 4+2 with no bubble.
- Fairness: all three requesters continuously valid, out_ready=1 → grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,0… and req_ready one-hot every cycle.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 → out_data stable, all req_ready=0, burst_cnt frozen; on release the next word follows 1 cycle later.
- Early burst end: req0 supplies 2 words then drops valid while req2 is valid → req2 granted on the next cycle and rr_ptr=1 afterwards.
- Reset mid-burst: reset asserted while out_valid=1, owner=2, burst_cnt=3 → next cycle out_valid=0, owner=0, busy=0 with inputs idle.
- GT_TX_ARB_STATS_EN: 10 grants to req0 and 3 to req1, then stats_clear → counts read 10 and 3, then 0 and 0.
